// File: rtl/dcpu_pkg.sv
// Shared types and constants for the DCPU main-memory block.
package dcpu_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_PEND,
    D_ACK
  } dev_state_t;

  localparam int unsigned DCPU_RAM_WORDS = 65536;

endpackage

// File: rtl/dcpu_ram_array.sv
// Plain single-port synchronous word RAM (read-first), no reset; maps onto block RAM.
module dcpu_ram_array
  import dcpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             wdata,
  output word_t             rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dcpu_ram.sv
// DCPU main memory: core access port plus an optional device port (DCPU_RAM_DEV_PORT_EN)
// that is served only in cycles the core leaves idle.
module dcpu_ram
  import dcpu_pkg::*;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 255
) (
  input  logic        CORE_CLK,
  input  logic        RESET_N,
  input  logic        RAM_en,
  input  logic [15:0] RAM_addr,
  input  logic        RAM_wr,
  input  logic [15:0] RAM_out,
  output logic [15:0] RAM_data,
  input  logic        DEV_req,
  input  logic [15:0] DEV_addr,
  input  logic        DEV_wr,
  input  logic [15:0] DEV_wdata,
  output logic        DEV_ack,
  output logic [15:0] DEV_rdata,
  output logic        DEV_starved
);

  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  word_t             arr_wdata;
  word_t             arr_rdata;

  dcpu_ram_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (CORE_CLK),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // The array output changes every cycle; RAM_data follows it only after a core read
  // and otherwise shows the last value the core read.
  logic  core_rd_q;
  word_t ram_data_q;

  always_ff @(posedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      core_rd_q  <= 1'b0;
      ram_data_q <= '0;
    end else begin
      if (core_rd_q) begin
        ram_data_q <= arr_rdata;
      end
      core_rd_q <= RAM_en & ~RAM_wr;
    end
  end

  assign RAM_data = core_rd_q ? arr_rdata : ram_data_q;

`ifdef DCPU_RAM_DEV_PORT_EN

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] STARVE_SET = CNT_W'(STARVE_MAX - 1);

  dev_state_t        state_q;
  logic [ADDR_W-1:0] dev_addr_q;
  logic              dev_wr_q;
  word_t             dev_wdata_q;
  logic [CNT_W-1:0]  starve_q;
  logic              starved_q;
  logic              ack_q;
  logic              dev_rd_q;
  word_t             dev_rdata_q;
  logic              dev_go;

  assign dev_go = (state_q == D_PEND) && !RAM_en;

  always_comb begin
    arr_addr  = RAM_addr[ADDR_W-1:0];
    arr_we    = RAM_en & RAM_wr;
    arr_wdata = RAM_out;
    if (dev_go) begin
      arr_addr  = dev_addr_q;
      arr_we    = dev_wr_q;
      arr_wdata = dev_wdata_q;
    end
  end

  always_ff @(posedge CORE_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= D_IDLE;
      dev_addr_q  <= '0;
      dev_wr_q    <= 1'b0;
      dev_wdata_q <= '0;
      starve_q    <= '0;
      starved_q   <= 1'b0;
      ack_q       <= 1'b0;
      dev_rd_q    <= 1'b0;
      dev_rdata_q <= '0;
    end else begin
      if (dev_rd_q) begin
        dev_rdata_q <= arr_rdata;
      end
      dev_rd_q <= 1'b0;
      ack_q    <= 1'b0;
      unique case (state_q)
        D_IDLE: begin
          if (DEV_req) begin
            dev_addr_q  <= DEV_addr[ADDR_W-1:0];
            dev_wr_q    <= DEV_wr;
            dev_wdata_q <= DEV_wdata;
            state_q     <= D_PEND;
          end
        end
        D_PEND: begin
          if (!RAM_en) begin
            dev_rd_q <= ~dev_wr_q;
            state_q  <= D_ACK;
          end else begin
            if (starve_q != STARVE_LIM) begin
              starve_q <= starve_q + CNT_W'(1);
            end
            if (starve_q >= STARVE_SET) begin
              starved_q <= 1'b1;
            end
          end
        end
        D_ACK: begin
          ack_q    <= 1'b1;
          starve_q <= '0;
          state_q  <= D_IDLE;
        end
        default: state_q <= D_IDLE;
      endcase
    end
  end

  assign DEV_ack     = ack_q;
  assign DEV_rdata   = dev_rd_q ? arr_rdata : dev_rdata_q;
  assign DEV_starved = starved_q;

`else

  always_comb begin
    arr_addr  = RAM_addr[ADDR_W-1:0];
    arr_we    = RAM_en & RAM_wr;
    arr_wdata = RAM_out;
  end

  assign DEV_ack     = 1'b0;
  assign DEV_rdata   = '0;
  assign DEV_starved = 1'b0;

  logic unused_dev;
  assign unused_dev = ^{DEV_req, DEV_addr, DEV_wr, DEV_wdata};

`endif

endmodule
